// File: rtl/lbp_host_bridge.sv
// Host-side image bridge for the LBP engine: loads a gray image, serves engine reads and writes,
// then drains the result image with zeroed borders. Optional LBP_HOST_CHK_EN adds a sticky err.
module lbp_host_bridge #(
    parameter int unsigned IMG_LOG2 = 7,
    localparam int unsigned AW = 2 * IMG_LOG2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          gray_ready,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic [7:0]    gray_data,
    input  logic          lbp_valid,
    input  logic [AW-1:0] lbp_addr,
    input  logic [7:0]    lbp_data,
    input  logic          finish,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic          done,
    output logic          err
);

    localparam int unsigned Depth = 2 ** AW;
    localparam logic [AW-1:0] CntMax = '1;

    typedef enum logic [1:0] {StLoad, StServe, StDrain} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          gray_we, lbp_we;

    logic [7:0] gray_mem [Depth];
    logic [7:0] lbp_mem  [Depth];

    function automatic logic is_border(input logic [AW-1:0] a);
        logic [IMG_LOG2-1:0] row, col;
        row = a[AW-1:IMG_LOG2];
        col = a[IMG_LOG2-1:0];
        return (row == '0) || (row == '1) || (col == '0) || (col == '1);
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        ld_ready   = 1'b0;
        gray_ready = 1'b0;
        out_valid  = 1'b0;
        gray_we    = 1'b0;
        lbp_we     = 1'b0;
        unique case (state_q)
            StLoad: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    gray_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CntMax) begin
                        cnt_d   = '0;
                        state_d = StServe;
                    end
                end
            end
            StServe: begin
                gray_ready = 1'b1;
                lbp_we     = lbp_valid;
                if (finish) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntMax) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = StLoad;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StLoad;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Memories keep their contents across reset; a write in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!reset && gray_we) begin
            gray_mem[cnt_q] <= ld_data;
        end
        if (!reset && lbp_we) begin
            lbp_mem[lbp_addr] <= lbp_data;
        end
    end

    assign gray_data = gray_mem[gray_addr];
    assign out_data  = is_border(cnt_q) ? 8'h00 : lbp_mem[cnt_q];
    assign done      = done_q;

`ifdef LBP_HOST_CHK_EN
    logic err_q, err_d;
    logic in_serve;

    always_comb begin
        in_serve = (state_q == StServe);
        err_d    = err_q
                 | (gray_req & ~in_serve)
                 | (lbp_valid & (~in_serve | is_border(lbp_addr)))
                 | (finish & ~in_serve);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_gray_req;
    assign unused_gray_req = gray_req;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lbp_host_bridge.sv
// Directed + randomized bench for lbp_host_bridge; reference model holds the images as arrays
// and derives drained pixels from row/column arithmetic.
module tb_lbp_host_bridge;

    localparam int N    = 16384;
    localparam int SIDE = 128;
`ifdef LBP_HOST_CHK_EN
    localparam logic ErrExp = 1'b1;
`else
    localparam logic ErrExp = 1'b0;
`endif

    logic        clk, reset;
    logic        ld_valid, ld_ready, gray_ready, gray_req;
    logic [7:0]  ld_data, gray_data, lbp_data, out_data;
    logic [13:0] gray_addr, lbp_addr;
    logic        lbp_valid, finish, out_valid, out_ready, done, err;

    lbp_host_bridge #(.IMG_LOG2(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] ref_gray  [N];
    logic [7:0] ref_lbp   [N];
    bit         ref_known [N];
    logic [7:0] captured  [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit border(input int idx);
        int r, c;
        r = idx / SIDE;
        c = idx % SIDE;
        return (r == 0) || (r == SIDE - 1) || (c == 0) || (c == SIDE - 1);
    endfunction

    // Streams one full result image; stall_idx < 0 means no back-pressure.
    task automatic drain(input int stall_idx, output int bad, output int early, output int stall_bad);
        int idx = 0;
        int stall_left = 3;
        logic [7:0] exp;
        bad = 0; early = 0; stall_bad = 0;
        while (idx < N) begin
            @(negedge clk);
            out_ready = !(idx == stall_idx && stall_left > 0);
            #1;
            if (out_valid !== 1'b1) bad++;
            if (done !== 1'b0) early++;
            if (border(idx) || ref_known[idx]) begin
                exp = border(idx) ? 8'h00 : ref_lbp[idx];
                if (out_data !== exp) bad++;
                if (!out_ready && out_data !== exp) stall_bad++;
            end
            captured[idx] = out_data;
            if (out_ready) idx++;
            else stall_left--;
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
    endtask

    task automatic read_check(input string tag, input logic [13:0] a);
        @(negedge clk);
        gray_addr = a;
        #1;
        chk(tag, gray_data, ref_gray[a]);
    endtask

    initial begin
        int bad_rdy, bad_gr, bad, early, stall_bad, acc, cyc;
        logic [13:0] wa [3];
        logic [7:0]  wd [3];
        wa[0] = 14'h0081; wd[0] = 8'hA5;
        wa[1] = 14'h3F7E; wd[1] = 8'h5A;
        wa[2] = 14'd200;  wd[2] = 8'h3C;
        for (int i = 0; i < N; i++) ref_known[i] = 1'b0;

        reset = 1'b1; ld_valid = 1'b0; ld_data = '0; gray_req = 1'b0; gray_addr = '0;
        lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0; finish = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ld_ready", ld_ready, 1'b1);
        chk("rst_gray_ready", gray_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Ramp load at full rate.
        bad_rdy = 0; bad_gr = 0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_data  = 8'(i);
            ref_gray[i] = 8'(i);
            #1;
            if (ld_ready !== 1'b1) bad_rdy++;
            if (gray_ready !== 1'b0) bad_gr++;
        end
        chk("load1_ld_ready_all", bad_rdy, 0);
        chk("load1_gray_ready_early", bad_gr, 0);
        @(negedge clk);
        ld_valid  = 1'b0;
        gray_addr = 14'h0081;
        #1;
        chk("load1_gray_ready", gray_ready, 1'b1);
        chk("load1_ld_ready_low", ld_ready, 1'b0);
        chk("load1_read_0081", gray_data, 8'h81);
        for (int k = 0; k < 4; k++) read_check("load1_rand_read", 14'($urandom_range(N - 1)));

        // Engine writes, then a border write that only the checker flags.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            gray_req = 1'b1; lbp_valid = 1'b1; lbp_addr = wa[k]; lbp_data = wd[k];
            ref_lbp[wa[k]] = wd[k];
            ref_known[wa[k]] = 1'b1;
        end
        @(negedge clk);
        lbp_addr = 14'h0000; lbp_data = 8'hEE;
        @(negedge clk);
        lbp_valid = 1'b0;
        #1;
        chk("serve1_err", err, ErrExp);
        @(negedge clk);
        finish = 1'b1; gray_req = 1'b0;
        @(negedge clk);
        finish = 1'b0;
        #1;
        chk("finish_gray_ready_low", gray_ready, 1'b0);
        chk("drain1_out_valid", out_valid, 1'b1);

        drain(200, bad, early, stall_bad);
        chk("drain1_stream", bad, 0);
        chk("drain1_done_early", early, 0);
        chk("drain1_stall_stable", stall_bad, 0);
        chk("drain1_0081", captured[14'h0081], 8'hA5);
        chk("drain1_3F7E", captured[14'h3F7E], 8'h5A);
        chk("drain1_0000", captured[14'h0000], 8'h00);
        chk("drain1_007F", captured[14'h007F], 8'h00);
        chk("drain1_3F80", captured[14'h3F80], 8'h00);
        chk("drain1_3FFF", captured[14'h3FFF], 8'h00);
        chk("drain1_done", done, 1'b1);
        chk("drain1_ld_ready", ld_ready, 1'b1);
        chk("drain1_out_valid_low", out_valid, 1'b0);
        chk("drain1_err_sticky", err, ErrExp);
        @(negedge clk);
        #1;
        chk("drain1_done_one_cycle", done, 1'b0);

        // Random image with ld_valid alternating every cycle.
        acc = 0; cyc = 0; bad_gr = 0;
        while (acc < N && cyc < 2 * N + 4) begin
            @(negedge clk);
            ld_valid = cyc[0];
            ld_data  = 8'($urandom);
            #1;
            if (gray_ready !== 1'b0) bad_gr++;
            if (ld_valid && ld_ready) begin
                ref_gray[acc] = ld_data;
                acc++;
            end
            cyc++;
        end
        chk("load2_accepts", acc, N);
        chk("load2_gray_ready_early", bad_gr, 0);
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        chk("load2_gray_ready", gray_ready, 1'b1);
        read_check("load2_read_first", 14'h0000);
        read_check("load2_read_last", 14'h3FFF);
        for (int k = 0; k < 6; k++) read_check("load2_rand_read", 14'($urandom_range(N - 1)));

        // Random interior writes; the final one shares its cycle with finish.
        for (int k = 0; k < 100; k++) begin
            int r, c;
            r = int'($urandom_range(SIDE - 2, 1));
            c = int'($urandom_range(SIDE - 2, 1));
            @(negedge clk);
            lbp_valid = 1'b1;
            lbp_addr  = 14'(r * SIDE + c);
            lbp_data  = 8'($urandom);
            finish    = (k == 99);
            ref_lbp[r * SIDE + c] = lbp_data;
            ref_known[r * SIDE + c] = 1'b1;
        end
        @(negedge clk);
        lbp_valid = 1'b0; finish = 1'b0;
        #1;
        chk("serve2_gray_ready_low", gray_ready, 1'b0);
        chk("drain2_out_valid", out_valid, 1'b1);
        drain(-1, bad, early, stall_bad);
        chk("drain2_stream", bad, 0);
        chk("drain2_done_early", early, 0);
        chk("drain2_done", done, 1'b1);
        chk("drain2_ld_ready", ld_ready, 1'b1);

        // Reset in the middle of a load.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_data = 8'($urandom);
        end
        @(negedge clk);
        ld_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_ld_ready", ld_ready, 1'b1);
        chk("midrst_gray_ready", gray_ready, 1'b0);
        chk("midrst_err", err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
